// File: rtl/cpu_bus_adapter_pkg.sv
// cpu_bus_adapter_pkg
//   Shared definitions for the CPU-to-SoC bus adapter: the FSM state
//   encoding (BUS_ST_*) and the default bus timeout (BUS_TIMEOUT_DEFAULT).
//   Optional feature macro used by the adapter: KIANV_BUS_TIMEOUT_EN.
package cpu_bus_adapter_pkg;

  typedef enum logic [1:0] {
    BUS_ST_IDLE = 2'd0,
    BUS_ST_REQ  = 2'd1,
    BUS_ST_DONE = 2'd2
  } bus_state_e;

  localparam int unsigned BUS_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/cpu_bus_adapter_timeout.sv
// bus_timeout_counter
//   16-bit wait-cycle counter for the bus adapter. Only instantiated when
//   KIANV_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   clear        restart the count at zero (new bus request captured)
//   enable       count one wait cycle (request outstanding, no bus_ready)
//   expired      count has reached LIMIT-1
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == 16'(LIMIT - 1));

endmodule

// File: rtl/cpu_bus_adapter.sv
// cpu_bus_adapter
//   Converts the control unit's held memory request into a registered
//   valid/ready SoC bus transaction, returns read data with a one-cycle
//   cpu_ready pulse. With KIANV_BUS_TIMEOUT_EN defined, a request that the
//   slave never answers is ended after TIMEOUT_CYCLES with cpu_fault.
// Ports:
//   clk, resetn                         clock, async active-low reset
//   cpu_valid/addr/wdata/wstrb (in)     CPU request, wstrb==0 means read
//   cpu_ready/rdata/fault (out)         registered completion, data, fault
//   bus_valid/addr/wdata/wstrb (out)    registered bus request
//   bus_ready/rdata (in)                slave completion and read data
module cpu_bus_adapter
  import cpu_bus_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_fault,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cpu_bus_adapter: TIMEOUT_CYCLES out of range 2..65535");
  end

  bus_state_e  state, state_nxt;
  logic        bus_valid_nxt;
  logic [31:0] bus_addr_nxt;
  logic [31:0] bus_wdata_nxt;
  logic [3:0]  bus_wstrb_nxt;
  logic        cpu_ready_nxt;
  logic [31:0] cpu_rdata_nxt;
  logic        cpu_fault_nxt;

`ifdef KIANV_BUS_TIMEOUT_EN
  logic expired;

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   ((state == BUS_ST_IDLE) && cpu_valid),
    .enable  ((state == BUS_ST_REQ) && !bus_ready),
    .expired (expired)
  );
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= BUS_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic; every output is registered below so
  // nothing from bus_ready/bus_rdata reaches a port combinationally.
  always_comb begin
    state_nxt     = state;
    bus_valid_nxt = bus_valid;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_wstrb_nxt = bus_wstrb;
    cpu_ready_nxt = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    cpu_fault_nxt = 1'b0;
    case (state)
      BUS_ST_IDLE: begin
        if (cpu_valid) begin
          bus_addr_nxt  = cpu_addr;
          bus_wdata_nxt = cpu_wdata;
          bus_wstrb_nxt = cpu_wstrb;
          bus_valid_nxt = 1'b1;
          state_nxt     = BUS_ST_REQ;
        end
      end
      BUS_ST_REQ: begin
        // bus_ready takes priority over an expiry in the same cycle.
        if (bus_ready) begin
          bus_valid_nxt = 1'b0;
          cpu_ready_nxt = 1'b1;
          if (bus_wstrb == 4'd0) begin
            cpu_rdata_nxt = bus_rdata;
          end
          state_nxt = BUS_ST_DONE;
        end
`ifdef KIANV_BUS_TIMEOUT_EN
        else if (expired) begin
          bus_valid_nxt = 1'b0;
          cpu_ready_nxt = 1'b1;
          cpu_fault_nxt = 1'b1;
          cpu_rdata_nxt = 32'd0;
          state_nxt     = BUS_ST_DONE;
        end
`endif
      end
      BUS_ST_DONE: begin
        // cpu_valid is still high here; it is not a new request.
        state_nxt = BUS_ST_IDLE;
      end
      default: begin
        state_nxt     = BUS_ST_IDLE;
        bus_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      bus_valid <= bus_valid_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
      bus_wstrb <= bus_wstrb_nxt;
      cpu_ready <= cpu_ready_nxt;
      cpu_rdata <= cpu_rdata_nxt;
    end
  end

`ifdef KIANV_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_fault <= 1'b0;
    end else begin
      cpu_fault <= cpu_fault_nxt;
    end
  end
`else
  assign cpu_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_adapter.sv
// tb_cpu_bus_adapter
//   Self-checking bench for cpu_bus_adapter. A transaction-level model keeps
//   the expected cpu_rdata and the expected cycle-by-cycle handshake of each
//   request; a simple slave answers after a chosen number of wait cycles.
//   Timeout scenarios are exercised when KIANV_BUS_TIMEOUT_EN is defined.
module tb_cpu_bus_adapter;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_fault;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int          n_checks;
  int          n_fail;
  logic [31:0] model_rdata;

  cpu_bus_adapter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_fault (cpu_fault),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge of an idle cycle; returns at the falling edge
  // of the idle cycle following the completion pulse.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int w, input logic [31:0] rd);
    check("idle_bus_valid", bus_valid, 32'd0);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wstrb = s;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      check("req_bus_valid", bus_valid, 32'd1);
      check("req_bus_addr", bus_addr, a);
      check("req_bus_wdata", bus_wdata, d);
      check("req_bus_wstrb", bus_wstrb, 32'(s));
      check("req_cpu_ready", cpu_ready, 32'd0);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_wstrb = 4'($urandom);
      if (i == w) begin
        bus_ready = 1'b1;
        bus_rdata = rd;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
    end
    @(negedge clk);
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    if (s == 4'd0) model_rdata = rd;
    check("done_bus_valid", bus_valid, 32'd0);
    check("done_cpu_ready", cpu_ready, 32'd1);
    check("done_cpu_rdata", cpu_rdata, model_rdata);
    check("done_cpu_fault", cpu_fault, 32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    check("post_cpu_ready", cpu_ready, 32'd0);
    check("post_bus_valid", bus_valid, 32'd0);
  endtask

  task automatic idle_cycle(input logic spurious);
    bus_ready = spurious;
    bus_rdata = $urandom;
    @(negedge clk);
    bus_ready = 1'b0;
    check("idle_cpu_ready", cpu_ready, 32'd0);
    check("idle_bus_valid", bus_valid, 32'd0);
    check("idle_cpu_rdata", cpu_rdata, model_rdata);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_rdata = 32'd0;
    resetn      = 1'b0;
    cpu_valid   = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_wstrb   = '0;
    bus_ready   = 1'b0;
    bus_rdata   = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_valid", bus_valid, 32'd0);
    check("rst_cpu_ready", cpu_ready, 32'd0);
    check("rst_cpu_fault", cpu_fault, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_wstrb", bus_wstrb, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed: minimum-latency read, then write with 5 wait cycles,
    // issued back to back.
    do_txn(32'h8000_0010, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF);
    do_txn(32'h0000_0040, 32'h0000_1234, 4'b0011, 5, 32'h5555_AAAA);
    do_txn(32'h0000_0044, 32'h0, 4'b0000, 2, 32'h1357_9BDF);

    // Spurious bus_ready while idle.
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Randomised traffic with random gaps and stray bus_ready pulses.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      do_txn($urandom, $urandom, s, $urandom_range(0, 5), $urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        idle_cycle(1'($urandom));
      end
    end

    // Asynchronous reset while a request is outstanding.
    cpu_valid = 1'b1;
    cpu_addr  = 32'h1234_5678;
    cpu_wdata = 32'hCAFE_F00D;
    cpu_wstrb = 4'b1111;
    @(negedge clk);
    check("pre_rst_bus_valid", bus_valid, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("arst_bus_valid", bus_valid, 32'd0);
    check("arst_cpu_ready", cpu_ready, 32'd0);
    check("arst_bus_addr", bus_addr, 32'd0);
    check("arst_cpu_rdata", cpu_rdata, 32'd0);
    model_rdata = 32'd0;
    cpu_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_bus_valid", bus_valid, 32'd0);
    do_txn(32'h8000_0020, 32'h0, 4'b0000, 0, 32'h0BAD_CAFE);

`ifdef KIANV_BUS_TIMEOUT_EN
    // Slave never answers: bus_valid for TO cycles, then ready+fault.
    check("to_idle_bus_valid", bus_valid, 32'd0);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h9000_0000;
    cpu_wstrb = 4'd0;
    for (int i = 1; i <= int'(TO); i++) begin
      @(negedge clk);
      check("to_bus_valid", bus_valid, 32'd1);
      check("to_cpu_ready", cpu_ready, 32'd0);
    end
    @(negedge clk);
    model_rdata = 32'd0;
    check("to_done_bus_valid", bus_valid, 32'd0);
    check("to_done_cpu_ready", cpu_ready, 32'd1);
    check("to_done_cpu_fault", cpu_fault, 32'd1);
    check("to_done_cpu_rdata", cpu_rdata, 32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    check("to_post_cpu_ready", cpu_ready, 32'd0);
    check("to_post_cpu_fault", cpu_fault, 32'd0);
    // bus_ready arriving in the expiry cycle completes normally.
    do_txn(32'h9000_0004, 32'h0, 4'b0000, int'(TO) - 1, 32'hFACE_B00C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
